simplez_uart_tx: RTL and testbench
==================================

// Module: simplez_uart_tx
// PURPOSE
//  Memory-mapped serial transmitter on the Simplez data path, downstream of the CPU store cycle.
//  - Captures the low byte of data_in on a CPU write (esc) to its data address, buffers it and shifts it out as 8N1 on tx.
//  - Exposes a status word at a second address for busy-wait loops (LD/BZ).
//  - Top level muxes data_out onto busD when sel=1.
// PARAMETERS
//  ADDRW      9       address width (RA width)
//  DATAW      12      data width (busD width)
//  BAUD_DIV   104     clk cycles per serial bit; legal range 2..4095
//  ADDR_DATA  9'o500  write address: transmit holding register (THR)
//  ADDR_STAT  9'o501  read address: status; a write to it clears the overrun flag
// PORTS
//  clk       in   1      system clock; all state changes on negedge clk, same edge as the CPU
//  rst       in   1      asynchronous reset, active-high
//  addr      in   ADDRW  address from CPU RA
//  wr        in   1      write strobe (CPU esc)
//  data_in   in   DATAW  busD
//  data_out  out  DATAW  read data: status word when addr==ADDR_STAT, else 0
//  sel       out  1      addr==ADDR_DATA or addr==ADDR_STAT (combinational)
//  tx        out  1      serial line, idle high
//  busy      out  1      state!=IDLE or thr_full
// BEHAVIOUR
//  - Reset values: tx=1, busy=0, thr_full=0, ovr=0, state=IDLE, baud counter=0, bit index=0.
//    data_out and sel are combinational on addr only.
//  - Write acceptance, sampled at the edge where wr=1 and addr==ADDR_DATA:
//    - thr_full==0: THR<=data_in[7:0] and thr_full<=1.
//    - Otherwise the byte is dropped and ovr<=1.
//    - Writes and transfers at the same edge: the write sees the pre-edge thr_full, so a THR->shifter transfer on that edge still gives overrun.
//  - Overrun clear: wr=1 with addr==ADDR_STAT sets ovr<=0. Setting ovr wins if both happen at one edge (impossible: distinct addresses).
//  - Status word: {DATAW-3 zeros, ovr, thr_full, busy}.
//  - FSM states:
//    - IDLE: if thr_full, load shifter<=THR, thr_full<=0, counter<=0, go START.
//    - START: tx=0.
//    - DATA: bits LSB first, index 0..7.
//    - STOP: tx=1; after the bit time go IDLE.
//    - Each of START, each DATA bit and STOP holds for exactly BAUD_DIV clk cycles. Counter runs 0..BAUD_DIV-1, then wraps.
//  - Latency: write at edge N -> THR loaded at N -> transfer at N+1 -> tx falls after edge N+1.
//  - Frame length: 10*BAUD_DIV cycles (11*BAUD_DIV with parity).
//  - Back-to-back: a byte written during a frame is transferred on the edge after STOP completes (one IDLE cycle between frames).
//  - tx is a registered output; no glitches.
//  - Reset mid-frame: tx returns to 1 immediately (async), frame abandoned, THR contents discarded.
//  - Writes to other addresses are ignored. Reads have no side effects.
// CONFIGURATION
//  UART_TX_PARITY_EN
//  - Defined: a PARITY state between DATA and STOP sends even parity (XOR of the 8 data bits) for one bit time. Status bit 3 reads 1 (parity present).
//  - Undefined: 8N1, no PARITY state, status bit 3 reads 0.
// STRUCTURE
//  - Shared include simplez_defs.vh: DATAW/ADDRW defaults, I/O address map (ADDR_DATA, ADDR_STAT, LED address), status bit positions, FSM state encodings.
//  - Sub-module simplez_baud_gen: counter, parameter BAUD_DIV, inputs clk/rst/restart, output one-cycle tick at count BAUD_DIV-1.
//  - simplez_uart_tx holds the address decode, THR, ovr flag, shifter and FSM.
// TESTING  (BAUD_DIV=4 unless noted)
//  1. Assert rst mid-simulation -> tx=1, busy=0, data_out at ADDR_STAT = 12'o0000, sel=1 only for 9'o500/9'o501.
//  2. Write 12'h155 to 9'o500 -> tx low 4 cycles starting one edge later, then 1,0,1,0,1,0,1,0 at 4 cycles each, high 4 cycles; busy=0 after 41 edges.
//  3. Write 8'hA0, then 8'h0F while the first frame is in START -> two contiguous frames, exactly one IDLE cycle between them, ovr=0.
//  4. Three writes inside one frame -> third dropped, status=12'b111; write to 9'o501 -> ovr=0.
//  5. Assert rst during DATA bit 3 -> tx=1 without waiting for a clock edge; after release, no residual frame; a new write transmits correctly.
//  6. UART_TX_PARITY_EN defined, write 8'h07 -> parity bit 1 before STOP, frame length 44 cycles, status bit 3 = 1.

Source files
------------

// File: rtl/simplez_uart_tx_pkg.sv
// Shared types and address map for the Simplez serial transmitter.
// Default widths, I/O addresses, status bit positions and transmitter FSM encoding.
package simplez_uart_tx_pkg;

    localparam int ADDRW_DEF = 9;
    localparam int DATAW_DEF = 12;

    localparam logic [8:0] ADDR_DATA_DEF = 9'o500;
    localparam logic [8:0] ADDR_STAT_DEF = 9'o501;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_THR_FULL = 1;
    localparam int STAT_OVR      = 2;
    localparam int STAT_PARITY   = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/simplez_uart_tx_if.sv
// CPU-side memory-mapped bus seen by the transmitter: address, write strobe, write/read data, select.
interface simplez_uart_tx_if #(
    parameter int ADDRW = 9,
    parameter int DATAW = 12
);
    logic [ADDRW-1:0] addr;
    logic             wr;
    logic [DATAW-1:0] data_in;
    logic [DATAW-1:0] data_out;
    logic             sel;

    modport master (output addr, output wr, output data_in, input data_out, input sel);
    modport slave  (input addr, input wr, input data_in, output data_out, output sel);
endinterface

// File: rtl/simplez_baud_gen.sv
// Bit-time counter: one-cycle tick when the count reaches BAUD_DIV-1, then wraps to 0.
// Latency: tick is combinational from the count flop; restart forces the count to 0 at the next edge.
// Backpressure: none, free-running unless held in restart.
module simplez_baud_gen #(
    parameter int BAUD_DIV = 104
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);
    localparam int CW = 12;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CW'(BAUD_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (restart || tick) begin
            cnt_d = '0;
        end
    end

    // The CPU updates on the falling edge, so all state here does too.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/simplez_uart_tx.sv
// Memory-mapped 8N1 transmitter (8E1 when UART_TX_PARITY_EN is defined) with a one-byte holding register.
// Latency: write at edge N loads THR, edge N+1 moves it to the shifter and drives the start bit.
// Backpressure: none on the bus; a write while THR is full is dropped and sets the overrun flag.
module simplez_uart_tx
    import simplez_uart_tx_pkg::*;
#(
    parameter int               ADDRW     = ADDRW_DEF,
    parameter int               DATAW     = DATAW_DEF,
    parameter int               BAUD_DIV  = 104,
    parameter logic [ADDRW-1:0] ADDR_DATA = ADDR_DATA_DEF,
    parameter logic [ADDRW-1:0] ADDR_STAT = ADDR_STAT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    simplez_uart_tx_if.slave    bus,
    output logic                tx,
    output logic                busy
);
`ifdef UART_TX_PARITY_EN
    localparam logic PAR_PRESENT = 1'b1;
`else
    localparam logic PAR_PRESENT = 1'b0;
`endif

    tx_state_e  state_q, state_d;
    logic [7:0] thr_q, thr_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic       thr_full_q, thr_full_d;
    logic       ovr_q, ovr_d;
    logic       tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic       par_q, par_d;
`endif

    logic hit_data, hit_stat, tick;
    logic unused_data_hi;

    assign hit_data       = (bus.addr == ADDR_DATA);
    assign hit_stat       = (bus.addr == ADDR_STAT);
    assign bus.sel        = hit_data | hit_stat;
    assign unused_data_hi = ^bus.data_in[DATAW-1:8];

    assign busy = (state_q != ST_IDLE) | thr_full_q;
    assign tx   = tx_q;

    always_comb begin
        bus.data_out = '0;
        if (hit_stat) begin
            bus.data_out[STAT_BUSY]     = busy;
            bus.data_out[STAT_THR_FULL] = thr_full_q;
            bus.data_out[STAT_OVR]      = ovr_q;
            bus.data_out[STAT_PARITY]   = PAR_PRESENT;
        end
    end

    // Counter is held at 0 while idle so the start bit gets a full bit time.
    simplez_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
        .clk     (clk),
        .rst     (rst),
        .restart (state_q == ST_IDLE),
        .tick    (tick)
    );

    always_comb begin
        state_d    = state_q;
        thr_d      = thr_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        thr_full_d = thr_full_q;
        ovr_d      = ovr_q;
        tx_d       = tx_q;
`ifdef UART_TX_PARITY_EN
        par_d      = par_q;
`endif

        // Uses pre-edge thr_full, so a write coinciding with a transfer still overruns.
        if (bus.wr && hit_data) begin
            if (!thr_full_q) begin
                thr_d      = bus.data_in[7:0];
                thr_full_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (bus.wr && hit_stat) begin
            ovr_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (thr_full_q) begin
                    shift_d    = thr_q;
                    thr_full_d = 1'b0;
                    bit_idx_d  = '0;
                    tx_d       = 1'b0;
                    state_d    = ST_START;
`ifdef UART_TX_PARITY_EN
                    par_d      = even_parity(thr_q);
`endif
                end
            end
            ST_START: begin
                if (tick) begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = par_q;
                        state_d = ST_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    tx_d    = 1'b1;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            thr_q      <= '0;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            thr_full_q <= 1'b0;
            ovr_q      <= 1'b0;
            tx_q       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            thr_q      <= thr_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            thr_full_q <= thr_full_d;
            ovr_q      <= ovr_d;
            tx_q       <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end
endmodule

// File: tb/tb_simplez_uart_tx.sv
// Directed bench for simplez_uart_tx at BAUD_DIV=4; DUT updates on negedge, bench drives and samples on posedge.
module tb_simplez_uart_tx;
    import simplez_uart_tx_pkg::*;

    localparam int BD = 4;
`ifdef UART_TX_PARITY_EN
    localparam int   NB      = 11;
    localparam logic PAR_BIT = 1'b1;
`else
    localparam int   NB      = 10;
    localparam logic PAR_BIT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic tx, busy;

    simplez_uart_tx_if bus_if ();

    simplez_uart_tx #(.BAUD_DIV(BD)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus_if),
        .tx   (tx),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected serial frame, LSB first: start, 8 data bits, [even parity], stop.
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic [10:0] f;
        f = '1;
        f[0] = 1'b0;
        f[8:1] = b;
`ifdef UART_TX_PARITY_EN
        f[9] = ^b;
`endif
        return f;
    endfunction

    task automatic wr_reg(input logic [8:0] a, input logic [11:0] d);
        @(posedge clk);
        bus_if.addr    = a;
        bus_if.data_in = d;
        bus_if.wr      = 1'b1;
        @(posedge clk);
        bus_if.wr      = 1'b0;
    endtask

    task automatic chk_stat(input string tag, input logic [11:0] exp);
        bus_if.addr = 9'o501;
        #1;
        chk(tag, bus_if.data_out, exp);
    endtask

    // Samples every cycle of one frame; optionally issues data writes after samples wa0/wa1.
    task automatic check_frame(input string tag, input logic [7:0] b,
                               input int wa0, input int wa1, input logic [11:0] wd);
        logic [10:0] fr;
        fr = frame_of(b);
        for (int k = 0; k < NB * BD; k++) begin
            @(posedge clk);
            chk($sformatf("%s_tx%0d", tag, k), tx, fr[k / BD]);
            if (k == wa0 || k == wa1) begin
                bus_if.addr    = 9'o500;
                bus_if.data_in = wd;
                bus_if.wr      = 1'b1;
            end else begin
                bus_if.wr = 1'b0;
            end
        end
        bus_if.wr = 1'b0;
    endtask

    initial begin
        logic low_seen;
        rst            = 1'b1;
        bus_if.wr      = 1'b0;
        bus_if.addr    = '0;
        bus_if.data_in = '0;
        repeat (3) @(posedge clk);
        rst = 1'b0;

        // 1: reset asserted mid-frame
        wr_reg(9'o500, 12'h0C3);
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk_stat("rst_stat", {8'h00, PAR_BIT, 3'b000});
        bus_if.addr = 9'o500; #1 chk("sel_500", bus_if.sel, 1'b1);
        bus_if.addr = 9'o501; #1 chk("sel_501", bus_if.sel, 1'b1);
        bus_if.addr = 9'o502; #1 chk("sel_502", bus_if.sel, 1'b0);
        bus_if.addr = 9'o000; #1 chk("sel_000", bus_if.sel, 1'b0);
        bus_if.addr = 9'o502; #1 chk("dout_502", bus_if.data_out, 12'h000);
        @(posedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // 2: single frame of 0x55
        wr_reg(9'o500, 12'h155);
        chk("t2_tx_before", tx, 1'b1);
        chk("t2_busy_thr", busy, 1'b1);
        check_frame("t2", 8'h55, -1, -1, 12'h000);
        @(posedge clk);
        chk("t2_busy_end", busy, 1'b0);
        chk("t2_tx_end", tx, 1'b1);

        // 3: second byte written during START gives back-to-back frames
        wr_reg(9'o500, 12'h0A0);
        check_frame("t3a", 8'hA0, 0, -1, 12'h00F);
        @(posedge clk);
        chk("t3_gap_tx", tx, 1'b1);
        chk("t3_gap_busy", busy, 1'b1);
        check_frame("t3b", 8'h0F, -1, -1, 12'h000);
        @(posedge clk);
        chk("t3_busy_end", busy, 1'b0);
        chk_stat("t3_stat", {8'h00, PAR_BIT, 3'b000});

        // 4: three writes in one frame, third overruns; status write clears ovr
        wr_reg(9'o500, 12'h033);
        check_frame("t4", 8'h33, 0, 5, 12'h044);
        chk_stat("t4_stat_ovr", {8'h00, PAR_BIT, 3'b111});
        wr_reg(9'o501, 12'h000);
        chk_stat("t4_stat_clr", {8'h00, PAR_BIT, 3'b001});
        repeat (NB * BD) @(posedge clk);
        chk("t4_busy_end", busy, 1'b0);

        // 5: reset during data bit 3
        wr_reg(9'o500, 12'h0F0);
        repeat (18) @(posedge clk);
        chk("t5_pre_tx", tx, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("t5_async_tx", tx, 1'b1);
        chk("t5_async_busy", busy, 1'b0);
        @(posedge clk);
        rst = 1'b0;
        low_seen = 1'b0;
        repeat (50) begin
            @(posedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) low_seen = 1'b1;
        end
        chk("t5_no_residual", low_seen, 1'b0);
        wr_reg(9'o500, 12'h096);
        check_frame("t5", 8'h96, -1, -1, 12'h000);
        @(posedge clk);
        chk("t5_busy_end", busy, 1'b0);

        // 6: 0x07 has odd weight, so the parity bit (when present) is 1
        wr_reg(9'o500, 12'h007);
        chk_stat("t6_stat_bit3", {8'h00, PAR_BIT, 3'b011});
        check_frame("t6", 8'h07, -1, -1, 12'h000);
        @(posedge clk);
        chk("t6_busy_end", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
